// File: rtl/ctest_nios_switch_pkg.sv
// ctest_nios_switch_pkg: register map and edge polarity encoding for the switch controller.
package ctest_nios_switch_pkg;
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;
  typedef enum logic {EDGE_RISE = 1'b0, EDGE_FALL = 1'b1} edge_pol_e;
endpackage

// File: rtl/ctest_nios_switch_debounce.sv
// ctest_nios_switch_debounce: two-flop synchroniser plus tick-qualified debounce for one switch bit.
module ctest_nios_switch_debounce
  import ctest_nios_switch_pkg::*;
#(
  parameter int DB_COUNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_deb,
  output logic o_deb_next
);
  localparam int CW = $clog2(DB_COUNT + 1);
  logic          r_s1, r_s2, r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_last;
  assign w_last     = i_tick && (r_cnt == CW'(DB_COUNT - 1));
  assign o_deb_next = (r_s2 != r_deb && w_last) ? r_s2 : r_deb;
  assign o_deb      = r_deb;
  // any tick where the level matches again restarts qualification
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1  <= i_raw;
      r_s2  <= r_s1;
      r_deb <= o_deb_next;
      r_cnt <= (r_s2 == r_deb || w_last) ? '0 : i_tick ? r_cnt + 1'b1 : r_cnt;
    end
endmodule

// File: rtl/ctest_nios_switch_ctrl.sv
// ctest_nios_switch_ctrl: Avalon-MM switch bank slave with debounce, edge capture and maskable irq.
module ctest_nios_switch_ctrl
  import ctest_nios_switch_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000,
  parameter int DB_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int DW = $clog2(TICK_DIV);
  logic [DW-1:0]    r_div;
  logic [WIDTH-1:0] r_mask, r_sel, r_cap;
  logic [31:0]      r_rd;
  logic [WIDTH-1:0] w_deb, w_deb_next, w_ev, w_w1c, w_rsel;
  logic             w_tick, w_wr, w_unused;
  assign w_tick   = r_div == DW'(TICK_DIV - 1);
  assign w_wr     = chipselect & write;
  assign w_w1c    = (w_wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
  assign w_unused = &{1'b0, writedata};
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ctest_nios_switch_debounce #(.DB_COUNT(DB_COUNT)) u_db (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_tick     (w_tick),
      .i_raw      (in_port[i]),
      .o_deb      (w_deb[i]),
      .o_deb_next (w_deb_next[i])
    );
    assign w_ev[i] = (edge_pol_e'(r_sel[i]) == EDGE_FALL) ? (w_deb[i] & ~w_deb_next[i])
                                                          : (w_deb_next[i] & ~w_deb[i]);
  end
  always_comb
    w_rsel = (address == ADDR_DATA)     ? w_deb  :
             (address == ADDR_IRQ_MASK) ? r_mask :
             (address == ADDR_EDGE_SEL) ? r_sel  : r_cap;
  // a new event outranks a same-cycle write-1-to-clear so no edge is lost
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_div  <= '0;
      r_mask <= '0;
      r_sel  <= '0;
      r_cap  <= '0;
      r_rd   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_wr && address == ADDR_IRQ_MASK) r_mask <= writedata[WIDTH-1:0];
      if (w_wr && address == ADDR_EDGE_SEL) r_sel <= writedata[WIDTH-1:0];
      r_cap <= (r_cap & ~w_w1c) | w_ev;
      r_rd  <= 32'(w_rsel);
    end
  assign readdata = r_rd;
  assign irq      = |(r_cap & r_mask);
endmodule

// File: tb/tb_ctest_nios_switch_ctrl.sv
// tb_ctest_nios_switch_ctrl: directed self-checking bench for the switch controller.
module tb_ctest_nios_switch_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port = 8'd0;
  logic [31:0] readdata;
  logic        irq;
  int          checks = 0, errors = 0, ecount;
  logic [31:0] d;
  int          n;
  logic        bad;

  ctest_nios_switch_ctrl #(.WIDTH(8), .TICK_DIV(4), .DB_COUNT(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  // edges since reset release; a prescaler tick lands on every edge where this becomes a multiple of 4
  always @(posedge clk) ecount <= reset_n ? ecount + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clks(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] q);
    address = a;
    clks(1);
    q = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; writedata = v; chipselect = 1'b1; write = 1'b1;
    clks(1);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic poll(input string tag, input logic [1:0] a, input logic [31:0] exp, input int max, output int k);
    address = a;
    k = 0;
    do begin
      clks(1);
      k++;
    end while (readdata !== exp && k < max);
    chk(tag, readdata, exp);
  endtask

  initial begin
    in_port = 8'hFF;
    clks(3);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    address = 2'd0;
    reset_n = 1'b1;
    poll("t1_data", 2'd0, 32'hFF, 20, n);
    chk("t1_latency", {31'd0, n >= 12 && n <= 16}, 32'h1);
    rd(2'd3, d); chk("t1_cap", d, 32'hFF);
    chk("t1_irq_masked", {31'd0, irq}, 32'h0);
    wr(2'd3, 32'hFF);
    rd(2'd3, d); chk("t1_cap_clr", d, 32'h0);

    in_port = 8'h00;
    clks(20);
    rd(2'd0, d); chk("t2_data0", d, 32'h0);
    wr(2'd3, 32'hFF);
    in_port = 8'h05;
    clks(7);
    rd(2'd0, d); chk("t2_data_hold", d, 32'h0);
    poll("t2_data", 2'd0, 32'h05, 16, n);
    rd(2'd3, d); chk("t2_cap", d, 32'h05);
    chk("t2_irq", {31'd0, irq}, 32'h0);

    in_port = 8'h00;
    clks(20);
    wr(2'd3, 32'hFF);
    bad = 1'b0;
    address = 2'd0;
    for (int i = 0; i < 200; i++) begin
      if (i % 5 == 0) in_port[0] = ~in_port[0];
      clks(1);
      if (readdata[0] !== 1'b0) bad = 1'b1;
    end
    chk("t3_bounce_data", {31'd0, bad}, 32'h0);
    in_port = 8'h00;
    clks(20);
    rd(2'd3, d); chk("t3_bounce_cap", d, 32'h0);

    wr(2'd1, 32'h01);
    rd(2'd1, d); chk("t4_mask", d, 32'h01);
    in_port = 8'h01;
    poll("t4_cap", 2'd3, 32'h01, 24, n);
    chk("t4_irq_set", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h01);
    chk("t4_irq_clr", {31'd0, irq}, 32'h0);
    rd(2'd3, d); chk("t4_cap_clr", d, 32'h0);

    wr(2'd2, 32'h02);
    rd(2'd2, d); chk("t5_sel", d, 32'h02);
    in_port = 8'h03;
    clks(20);
    rd(2'd0, d); chk("t5_data_hi", d, 32'h03);
    rd(2'd3, d); chk("t5_no_rise", d, 32'h0);
    in_port = 8'h01;
    clks(20);
    rd(2'd3, d); chk("t5_fall", d, 32'h02);
    chk("t5_irq", {31'd0, irq}, 32'h0);

    in_port = 8'h00;
    clks(20);
    wr(2'd2, 32'h00);
    wr(2'd3, 32'hFF);
    rd(2'd3, d); chk("t6_cap_clean", d, 32'h0);
    while (ecount % 4 != 0) clks(1);
    in_port = 8'h01;
    clks(11);
    chk("t6_irq_before", {31'd0, irq}, 32'h0);
    wr(2'd3, 32'h01);
    chk("t6_irq_set_wins", {31'd0, irq}, 32'h1);
    rd(2'd3, d); chk("t6_cap_set_wins", d, 32'h01);

    in_port = 8'h05;
    clks(9);
    reset_n = 1'b0;
    clks(2);
    chk("t7_rst_readdata", readdata, 32'h0);
    chk("t7_rst_irq", {31'd0, irq}, 32'h0);
    address = 2'd0;
    reset_n = 1'b1;
    clks(7);
    rd(2'd0, d); chk("t7_fresh_count", d, 32'h0);
    rd(2'd3, d); chk("t7_cap_discarded", d, 32'h0);
    rd(2'd1, d); chk("t7_mask_reset", d, 32'h0);
    poll("t7_data", 2'd0, 32'h05, 16, n);
    rd(2'd3, d); chk("t7_cap_after", d, 32'h05);
    chk("t7_irq", {31'd0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctest_nios_switch_ctrl.md
Name: ctest_nios_switch_ctrl

Overview:
Avalon-MM slave controller for the board switch bank.
- Synchronises and debounces WIDTH raw switch inputs.
- Captures per-bit edges with software-selected polarity.
- Raises a maskable interrupt to the Nios II.
- Sits between the switch pins and the system interconnect.

Parameters:
WIDTH, 8, number of switch inputs (1..32)
TICK_DIV, 50000, clk cycles per debounce sample tick (1 ms at 50 MHz); must be >=2
DB_COUNT, 4, consecutive ticks a new level must persist before it is accepted; must be >=1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register word address
chipselect  in  1  slave select
write  in  1  write strobe, active-high, qualified by chipselect
writedata  in  32  write data
in_port  in  WIDTH  raw switch pins, asynchronous to clk
readdata  out  32  registered read data
irq  out  1  interrupt request, active-high, level

Behaviour:
Interface rules:
- Reset is reset_n, asynchronous, active-low; clock is clk.
- All state is reset by reset_n and clocked on the rising edge of clk.

Register map (unused upper bits read as 0, writes to them are ignored):
- 0 DATA: read-only, debounced switch state.
- 1 IRQ_MASK: read/write; 1 enables the irq contribution of that bit.
- 2 EDGE_SEL: read/write; 0 captures rising edges, 1 captures falling edges.
- 3 EDGE_CAP: read, write-1-to-clear.

Read path:
- readdata <= zero-extended register selected by address, every cycle.
- Read latency is 1 clk, with no wait states.
- Reads have no side effects.

Write path:
- Takes effect on the clk edge where chipselect & write.
- Writes to DATA are ignored.

Synchroniser:
- Two flops per bit: sync = in_port delayed 2 clk.

Prescaler:
- Counts 0..TICK_DIV-1 and wraps to 0.
- tick is a 1-cycle pulse when the count equals TICK_DIV-1.

Per-bit debounce (counter width clog2(DB_COUNT+1)):
- sync == deb: cnt <= 0 on every clk, so any bounce restarts qualification.
- sync != deb and tick:
  - If cnt == DB_COUNT-1, deb <= sync and cnt <= 0.
  - Otherwise cnt <= cnt+1.
- Consequence: deb changes only on a tick, after DB_COUNT consecutive differing ticks.

Edge detect:
- rise = deb_next & ~deb; fall = ~deb_next & deb.
- ev = EDGE_SEL ? fall : rise.

EDGE_CAP update:
- cap <= (cap & ~w1c) | ev.
- When a set and a clear hit the same bit in the same cycle, set wins.

irq:
- irq = |(EDGE_CAP & IRQ_MASK), a function of flops only, with no input-to-output path.

Reset values:
- readdata, irq, DATA, IRQ_MASK, EDGE_SEL, EDGE_CAP, all counters and synchroniser flops are 0.
- Switches held high through reset produce a rising edge after debounce, and EDGE_CAP sets.
- Software clears EDGE_CAP after init; this is intended.

Reset mid-operation:
- Any partial debounce count or pending capture is discarded.
- No edge is generated by the reset itself.

Decomposition:
- Package ctest_nios_switch_pkg holds:
  - Register address constants (ADDR_DATA=0, ADDR_IRQ_MASK=1, ADDR_EDGE_SEL=2, ADDR_EDGE_CAP=3).
  - Edge polarity encoding constants.
- Sub-module ctest_nios_switch_debounce: one bit of synchroniser plus debounce counter.
  - Inputs: clk, reset_n, tick, raw bit.
  - Output: deb.
  - Instanced WIDTH times by generate.
- The prescaler, register file and edge logic stay in the top.

Test Plan:
All scenarios use TICK_DIV=4, DB_COUNT=3, WIDTH=8.
1. Assert reset_n=0 with in_port=0xFF, then release → readdata=0 and irq=0 during reset. DATA reads 0xFF no earlier than 3 ticks and no later than 16 clk after release. EDGE_CAP=0xFF, irq stays 0 because IRQ_MASK=0.
2. Step in_port 0x00→0x05 and hold → DATA unchanged for the first 2 ticks, reads 0x05 within 16 clk. EDGE_CAP=0x05 with EDGE_SEL=0.
3. Toggle in_port[0] every 5 clk for 200 clk → DATA[0] stays 0, EDGE_CAP[0] stays 0.
4. Write IRQ_MASK=0x01, then raise bit0 and hold → EDGE_CAP=0x01, irq=1. Write 0x01 to addr 3 → EDGE_CAP=0, irq=0 on the next clk.
5. Write EDGE_SEL=0x02, then hold bit1 high, then low → rise not captured, fall sets EDGE_CAP=0x02.
6. Align a W1C of 0x01 to addr 3 with the clk where bit0's debounced edge fires → EDGE_CAP[0]=1 afterwards. Separately, pulse reset_n mid-debounce → cnt discarded, no capture.
